// File: rtl/if_write_address_generator.sv
// Write-side address generator for the input-feature scratchpad.
// Accepts IF words over a valid/ready handshake, writes one row at
// addresses 0..row_len-1, holds the row until the read side pulses
// next_row, and repeats for the programmed number of rows.
module if_write_address_generator #(
    parameter int unsigned POINTER_SIZE   = 8,
    parameter int unsigned ROW_LEN_SIZE   = 8,
    parameter int unsigned ROW_COUNT_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [ROW_LEN_SIZE-1:0]   i_row_len,
    input  logic [ROW_COUNT_SIZE-1:0] i_num_rows,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic                      i_next_row,
    output logic                      o_write_en,
    output logic [POINTER_SIZE-1:0]   o_write_pointer,
    output logic                      o_row_ready,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    r_state;
    logic [ROW_LEN_SIZE-1:0]   r_row_len;
    logic [ROW_COUNT_SIZE-1:0] r_num_rows;
    logic [ROW_LEN_SIZE-1:0]   r_wcnt;
    logic [ROW_COUNT_SIZE-1:0] r_rcnt;
    logic [POINTER_SIZE-1:0]   r_wptr;
    logic                      r_in_ready;
    logic                      r_row_ready;
    logic                      r_busy;
    logic                      r_done;

    logic w_handshake;
    logic w_last_word;
    logic w_last_row;
    logic w_zero_job;

    // Handshake and terminal-count decodes, compared at each register's own width
    assign w_handshake = i_in_valid & r_in_ready;
    assign w_last_word = (r_wcnt == (r_row_len - ROW_LEN_SIZE'(1)));
    assign w_last_row  = (r_rcnt == (r_num_rows - ROW_COUNT_SIZE'(1)));
    assign w_zero_job  = (i_row_len == '0) || (i_num_rows == '0);

    // Write strobe is valid in the handshake cycle itself
    assign o_write_en      = w_handshake;
    assign o_write_pointer = r_wptr;
    assign o_in_ready      = r_in_ready;
    assign o_row_ready     = r_row_ready;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

    // Fill/hold control FSM with state-decoded flags registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_row_len   <= '0;
            r_num_rows  <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_wptr      <= '0;
            r_in_ready  <= 1'b0;
            r_row_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_row_len  <= i_row_len;
                        r_num_rows <= i_num_rows;
                        if (w_zero_job) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FILL;
                            r_wcnt     <= '0;
                            r_rcnt     <= '0;
                            r_wptr     <= '0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (w_handshake) begin
                        if (w_last_word) begin
                            r_state     <= S_HOLD;
                            r_wcnt      <= '0;
                            r_wptr      <= '0;
                            r_in_ready  <= 1'b0;
                            r_row_ready <= 1'b1;
                        end else begin
                            r_wcnt <= r_wcnt + ROW_LEN_SIZE'(1);
                            r_wptr <= r_wptr + POINTER_SIZE'(1);
                        end
                    end
                end
                S_HOLD: begin
                    // next_row wins over a coincident start, which is ignored here
                    if (i_next_row) begin
                        r_rcnt      <= r_rcnt + ROW_COUNT_SIZE'(1);
                        r_row_ready <= 1'b0;
                        if (w_last_row) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FILL;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_row_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_write_address_generator.sv
// Self-checking bench for if_write_address_generator: directed test-plan
// steps followed by random traffic, all checked against a job-level model.
module tb_if_write_address_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] row_len;
    logic [7:0] num_rows;
    logic       in_valid;
    logic       in_ready;
    logic       next_row;
    logic       write_en;
    logic [7:0] write_pointer;
    logic       row_ready;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    // Job-level reference model: words accepted and rows released so far
    bit m_active;
    bit m_done;
    int m_acc;
    int m_rel;
    int m_rl;
    int m_nr;

    logic [7:0] wlog[$];

    if_write_address_generator #(
        .POINTER_SIZE  (8),
        .ROW_LEN_SIZE  (8),
        .ROW_COUNT_SIZE(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_row_len      (row_len),
        .i_num_rows     (num_rows),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_next_row     (next_row),
        .o_write_en     (write_en),
        .o_write_pointer(write_pointer),
        .o_row_ready    (row_ready),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_holding();
        return m_active && (m_acc >= (m_rel + 1) * m_rl);
    endfunction

    // Compare every output against the model for the current cycle
    task automatic check_outputs(input string tag);
        bit exp_rdy;
        int exp_ptr;
        exp_rdy = m_active && !m_holding();
        exp_ptr = exp_rdy ? (m_acc % m_rl) % 256 : 0;
        check({tag, ".in_ready"},  32'(in_ready),      32'(exp_rdy));
        check({tag, ".write_en"},  32'(write_en),      32'(exp_rdy & in_valid));
        check({tag, ".wptr"},      32'(write_pointer), 32'(exp_ptr));
        check({tag, ".row_ready"}, 32'(row_ready),     32'(m_active && m_holding()));
        check({tag, ".busy"},      32'(busy),          32'(m_active));
        check({tag, ".done"},      32'(done),          32'(m_done));
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_acc    = 0;
        m_rel    = 0;
        m_rl     = 0;
        m_nr     = 0;
    endtask

    // One clock cycle: drive at negedge, check, advance the model at posedge
    task automatic step(input string tag, input logic st, input logic [7:0] rl,
                        input logic [7:0] nr, input logic iv, input logic nx);
        start    = st;
        row_len  = rl;
        num_rows = nr;
        in_valid = iv;
        next_row = nx;
        #1;
        check_outputs(tag);
        if (write_en === 1'b1) wlog.push_back(write_pointer);
        @(posedge clk);
        if (!m_active) begin
            if (st) begin
                m_rl = int'(rl);
                m_nr = int'(nr);
                if (rl == 8'd0 || nr == 8'd0) begin
                    m_done = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_done   = 1'b0;
                    m_acc    = 0;
                    m_rel    = 0;
                end
            end
        end else if (m_holding()) begin
            if (nx) begin
                m_rel++;
                if (m_rel == m_nr) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (iv) begin
            m_acc++;
        end
        @(negedge clk);
    endtask

    // Assert reset at a negedge with inputs active, check the immediate clear
    task automatic do_reset(input string tag, input int cycles);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        repeat (cycles) @(negedge clk);
        check_outputs(tag);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int rl, input int rows);
        check({tag, ".count"}, 32'(wlog.size()), 32'(rl * rows));
        for (int i = 0; i < wlog.size() && i < rl * rows; i++)
            check({tag, ".addr"}, 32'(wlog[i]), 32'(i % rl));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; row_len = 8'd0; num_rows = 8'd0;
        in_valid = 1'b0; next_row = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset then idle
        do_reset("rst", 3);
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);

        // Single row, continuous input
        wlog.delete();
        step("r1.start", 1'b1, 8'd4, 8'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("r1.fill", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("r1.hold", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("r1.next", 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        step("r1.done", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check("r1.done_const", 32'(done), 32'd1);
        check_seq("r1.seq", 4, 1);

        // Gapped input, three rows
        wlog.delete();
        step("g3.start", 1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            step("g3.fill", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
            step("g3.gap",  1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            step("g3.fill", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
            step("g3.fill", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
            step("g3.hold", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            step("g3.hold", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            step("g3.next", 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        end
        step("g3.done", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check_seq("g3.seq", 3, 3);

        // Stray next_row in FILL, stray start in HOLD
        wlog.delete();
        step("st.start", 1'b1, 8'd5, 8'd2, 1'b0, 1'b0);
        step("st.fill",  1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("st.fill",  1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("st.nxfill", 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        step("st.fill",  1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("st.fill",  1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("st.sthold", 1'b1, 8'd2, 8'd1, 1'b0, 1'b0);
        step("st.next",  1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("st.fill2", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("st.both",  1'b1, 8'd2, 8'd1, 1'b0, 1'b1);
        step("st.done",  1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check_seq("st.seq", 5, 2);

        // Zero-size jobs
        wlog.delete();
        step("z.len0",  1'b1, 8'd0, 8'd2, 1'b1, 1'b0);
        step("z.after", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("z.nr0",   1'b1, 8'd3, 8'd0, 1'b1, 1'b0);
        step("z.after", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        check("z.nowrites", 32'(wlog.size()), 32'd0);

        // Reset mid-row, then a fresh job
        step("mr.start", 1'b1, 8'd8, 8'd1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("mr.fill", 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        do_reset("mr.rst", 1);
        wlog.delete();
        step("mr.start2", 1'b1, 8'd2, 8'd1, 1'b0, 1'b0);
        step("mr.fill2",  1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("mr.fill2",  1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step("mr.hold",   1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        check_seq("mr.seq", 2, 1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 ($urandom % 12) == 0,
                 8'($urandom % 6),
                 8'($urandom % 4),
                 1'($urandom % 2),
                 ($urandom % 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
